// File: rtl/count_sequencer.sv
// Run controller for the counter datapath: prescaled count tick, idle/run/hold/done sequencing.
// Optional down-count mode with a dir input is enabled by defining CNT_DOWN_EN.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | stopped, q and prescaler cleared
// RUN   | prescaler advancing, q steps on each tick
// HOLD  | paused, q and prescaler retained, no ticks
// DONE  | one-shot finished, q holds its final value
module count_sequencer #(
    parameter int PRESCALE = 25_000_000,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             reload_en,
    input  logic [CNT_W-1:0] limit,
`ifdef CNT_DOWN_EN
    input  logic             dir,
`endif
    output logic [CNT_W-1:0] q,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam int PRE_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

    state_t           st;
    logic [PRE_W-1:0] pre;
    logic [CNT_W-1:0] lim_r;
    logic             dir_r;
    logic             dir_in;

`ifdef CNT_DOWN_EN
    assign dir_in = dir;
`else
    assign dir_in = 1'b0;
`endif

    logic             at_term;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] reload_val;
    logic [CNT_W-1:0] step_val;

    assign at_term    = dir_r ? (q == '0) : (q == lim_r);
    assign load_val   = dir_in ? limit : '0;
    assign reload_val = dir_r ? lim_r : '0;
    assign step_val   = dir_r ? (q - 1'b1) : (q + 1'b1);
    assign state      = st;

    always_ff @(posedge clk) begin
        if (rst) begin
            st    <= IDLE;
            q     <= '0;
            pre   <= '0;
            lim_r <= '0;
            dir_r <= 1'b0;
            tick  <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            tick <= 1'b0;
            done <= 1'b0;
            case (st)
                IDLE, DONE: begin
                    if (stop) begin
                        st   <= IDLE;
                        q    <= '0;
                        pre  <= '0;
                        busy <= 1'b0;
                    end else if (start) begin
                        st    <= RUN;
                        busy  <= 1'b1;
                        lim_r <= limit;
                        dir_r <= dir_in;
                        q     <= load_val;
                        pre   <= '0;
                    end
                end
                RUN: begin
                    if (stop) begin
                        st   <= IDLE;
                        q    <= '0;
                        pre  <= '0;
                        busy <= 1'b0;
                    end else if (tick && at_term && !reload_en) begin
                        st   <= DONE;
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        // the tick issued last cycle is applied to q even if pause arrives now
                        if (tick) begin
                            q    <= at_term ? reload_val : step_val;
                            done <= at_term;
                        end
                        if (pause) begin
                            st <= HOLD;
                        end else if (pre == PRE_MAX) begin
                            pre  <= '0;
                            tick <= 1'b1;
                        end else begin
                            pre <= pre + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (stop) begin
                        st   <= IDLE;
                        q    <= '0;
                        pre  <= '0;
                        busy <= 1'b0;
                    end else if (start) begin
                        st <= RUN;
                    end
                end
                default: begin
                    st   <= IDLE;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer with PRESCALE=4: vector table, directed corners,
// and randomized commands against a behavioural model.
module tb_count_sequencer;

    localparam int PRESCALE = 4;
    localparam int CNT_W    = 4;
`ifdef CNT_DOWN_EN
    localparam bit HAS_DOWN = 1'b1;
`else
    localparam bit HAS_DOWN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst, start, stop, pause, reload_en, dir_sig;
    logic [CNT_W-1:0] limit, q;
    logic             tick, busy, done;
    logic [1:0]       state;

    int vectors = 0;
    int miscompares = 0;

    count_sequencer #(.PRESCALE(PRESCALE), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .reload_en(reload_en), .limit(limit),
`ifdef CNT_DOWN_EN
        .dir(dir_sig),
`endif
        .q(q), .tick(tick), .busy(busy), .done(done), .state(state)
    );

    always #5 clk = ~clk;

    // model: mode numbers follow the output encoding 0=idle 1=run 2=hold 3=done
    int m_st, m_q, m_pre, m_lim, m_dir;
    bit m_tick, m_busy, m_done;

    task automatic model_step(input bit r, s, sp, p, rl, input int lim, input bit d);
        bit pending;
        bit term;
        pending = m_tick;
        m_tick = 0;
        m_done = 0;
        if (r) begin
            m_st = 0; m_q = 0; m_pre = 0; m_lim = 0; m_dir = 0;
        end else if (m_st == 1) begin
            if (sp) begin
                m_st = 0; m_q = 0; m_pre = 0;
            end else begin
                if (pending) begin
                    term = m_dir ? (m_q == 0) : (m_q == m_lim);
                    if (term) begin
                        m_done = 1;
                        if (rl) m_q = m_dir ? m_lim : 0;
                        else    m_st = 3;
                    end else begin
                        m_q = m_dir ? m_q - 1 : m_q + 1;
                    end
                end
                if (m_st == 1) begin
                    if (p) m_st = 2;
                    else begin
                        m_pre = (m_pre + 1) % PRESCALE;
                        m_tick = (m_pre == 0);
                    end
                end
            end
        end else if (m_st == 2) begin
            if (sp) begin m_st = 0; m_q = 0; m_pre = 0; end
            else if (s) m_st = 1;
        end else begin
            if (sp) begin m_st = 0; m_q = 0; m_pre = 0; end
            else if (s) begin
                m_st = 1; m_lim = lim; m_dir = d; m_q = d ? lim : 0; m_pre = 0;
            end
        end
        m_busy = (m_st == 1) || (m_st == 2);
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int outs();
        return int'({state, q, tick, busy, done});
    endfunction

    function automatic int model_outs();
        logic [1:0] s2;
        logic [3:0] q4;
        s2 = m_st[1:0];
        q4 = m_q[3:0];
        return int'({s2, q4, m_tick, m_busy, m_done});
    endfunction

    task automatic cycle(input bit r, s, sp, p, rl, input int lim, input bit d, input bit chk);
        rst = r; start = s; stop = sp; pause = p; reload_en = rl;
        limit = lim[CNT_W-1:0]; dir_sig = d;
        @(posedge clk);
        model_step(r, s, sp, p, rl, lim, d);
        #1;
        if (chk) check("model {state,q,tick,busy,done}", outs(), model_outs());
    endtask

    task automatic run(input int n, input bit rl, input int lim);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, rl, lim, 0, 1);
    endtask

    typedef struct {
        bit s, sp, p, rl;
        int lim;
        int e_state, e_q;
        bit e_tick, e_busy, e_done;
    } vec_t;

    vec_t tbl[19];
    int   n, dones;
    bit   found;

    initial begin
        // one-shot, limit=3: ticks every 4 cycles, terminal on the 4th tick
        tbl[0] = '{1,0,0,0,3, 1,0,0,1,0};
        for (int i = 1; i < 4; i++)   tbl[i] = '{0,0,0,0,3, 1,0,0,1,0};
        tbl[4] = '{0,0,0,0,3, 1,0,1,1,0};
        for (int i = 5; i < 8; i++)   tbl[i] = '{0,0,0,0,3, 1,1,0,1,0};
        tbl[8] = '{0,0,0,0,3, 1,1,1,1,0};
        for (int i = 9; i < 12; i++)  tbl[i] = '{0,0,0,0,3, 1,2,0,1,0};
        tbl[12] = '{0,0,0,0,3, 1,2,1,1,0};
        for (int i = 13; i < 16; i++) tbl[i] = '{0,0,0,0,3, 1,3,0,1,0};
        tbl[16] = '{0,0,0,0,3, 1,3,1,1,0};
        tbl[17] = '{0,0,0,0,3, 3,3,0,0,1};
        tbl[18] = '{0,0,0,0,3, 3,3,0,0,0};

        cycle(1, 0, 0, 0, 0, 0, 0, 1);
        cycle(1, 1, 0, 1, 1, 7, 0, 1);
        check("reset outputs", outs(), 0);

        foreach (tbl[i]) begin
            cycle(0, tbl[i].s, tbl[i].sp, tbl[i].p, tbl[i].rl, tbl[i].lim, 0, 0);
            check($sformatf("oneshot vec %0d", i), outs(),
                  int'({tbl[i].e_state[1:0], tbl[i].e_q[3:0], tbl[i].e_tick, tbl[i].e_busy, tbl[i].e_done}));
        end

        // auto-reload, limit=2: three done pulses within 38 cycles, never DONE
        cycle(0, 1, 0, 0, 1, 2, 0, 1);
        dones = 0;
        found = 0;
        for (int i = 0; i < 38; i++) begin
            cycle(0, 0, 0, 0, 1, 2, 0, 1);
            dones += done;
            if (state == 2'b11) found = 1;
        end
        check("reload done count", dones, 3);
        check("reload never DONE", int'(found), 0);

        // pause two cycles after a tick, resume 10 cycles later: tick 2 cycles after re-entry
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle(0, 0, 0, 0, 1, 2, 0, 1);
            found = tick;
        end
        check("tick seen before pause", int'(found), 1);
        run(2, 1, 2);
        cycle(0, 0, 0, 1, 1, 2, 0, 1);
        check("pause enters HOLD", int'(state), 2);
        run(10, 1, 2);
        cycle(0, 1, 0, 0, 1, 2, 0, 1);
        n = 0;
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            cycle(0, 0, 0, 0, 1, 2, 0, 1);
            n++;
            found = tick;
        end
        check("resume tick latency", n, 2);

        // start+stop from HOLD goes to IDLE; reset mid-run clears everything
        cycle(0, 0, 0, 1, 1, 2, 0, 1);
        cycle(0, 1, 1, 0, 1, 2, 0, 1);
        check("start+stop from HOLD", int'({state, q}), 0);
        cycle(0, 1, 0, 0, 0, 9, 0, 1);
        run(9, 0, 9);
        cycle(1, 1, 0, 0, 0, 9, 0, 1);
        check("reset mid-run", outs(), 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1);

        // limit=0 one-shot: first tick is terminal
        cycle(0, 1, 0, 0, 0, 0, 0, 1);
        run(6, 0, 0);
        check("limit0 DONE q", int'({state, q}), int'({2'b11, 4'd0}));

        // limit change during RUN is ignored until restart
        cycle(0, 1, 0, 0, 0, 3, 0, 1);
        run(2, 0, 3);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle(0, 0, 0, 0, 0, 5, 0, 1);
            found = (state == 2'b11);
        end
        check("late limit reached DONE", int'(found), 1);
        check("late limit ignored", int'(q), 3);

        if (HAS_DOWN) begin
            cycle(0, 1, 0, 0, 0, 3, 1, 1);
            check("down start q", int'(q), 3);
            for (int i = 0; i < 22; i++) cycle(0, 0, 0, 0, 0, 3, 1, 1);
            check("down DONE q", int'({state, q}), int'({2'b11, 4'd0}));
        end

        // random commands against the model
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 199) == 0,
                  $urandom_range(0, 99) < 15,
                  $urandom_range(0, 99) < 3,
                  $urandom_range(0, 99) < 8,
                  $urandom_range(0, 99) < 50,
                  int'($urandom_range(0, 15)),
                  HAS_DOWN && ($urandom_range(0, 1) == 1),
                  1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/count_sequencer.md
# count_sequencer

Run controller for the 4-bit counter datapath. It owns the prescaler that produces the counter's count-enable tick and sequences the counter through idle, run, hold and terminal states. It supports one-shot and auto-reload operation against a programmable terminal count. It sits between the board-level push-button and switch inputs and the counter/display path, replacing the free-running divider-driven count.

## Interface
- PRESCALE, default 25_000_000: clk cycles per count tick; legal range ≥ 2.
- CNT_W, default 4: counter width.
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  level; begin, resume or restart counting.
- stop  input  1  level; abort to IDLE.
- pause  input  1  level; freeze counting.
- reload_en  input  1  1 = auto-reload at terminal, 0 = one-shot.
- limit  input  CNT_W  terminal count, latched on entry to RUN from IDLE or DONE.
- dir  input  1  0 = up, 1 = down; exists only with CNT_DOWN_EN.
- q  output  CNT_W  current count.
- tick  output  1  one-cycle count-enable pulse.
- busy  output  1  high in RUN or HOLD.
- done  output  1  one-cycle terminal pulse.
- state  output  2  IDLE=00, RUN=01, HOLD=10, DONE=11.

## Operation
- Reset values: state=IDLE, q=0, tick=0, busy=0, done=0. Internal prescaler pre=0 and latched limit lim_r=0.
- Command priority each cycle: stop > start > pause.
- IDLE:
  - q=0, pre=0.
  - start → RUN; latch lim_r←limit; pre←0; q←0.
- RUN:
  - pre increments each cycle; when pre==PRESCALE-1, pre←0 and tick=1 for that cycle.
  - On tick with q≠lim_r: q←q+1.
  - On tick with q==lim_r, this is the terminal event: done=1 for one cycle.
    - reload_en=1: q←0, stay in RUN.
    - reload_en=0: q holds lim_r, state→DONE.
  - pause (no stop) → HOLD; pre and q frozen; a tick due that same cycle is suppressed.
  - stop → IDLE; q←0, pre←0.
  - start is ignored.
- HOLD:
  - No ticks; q and pre are retained.
  - start → RUN; resumes from the retained pre, with no re-latch of limit.
  - stop → IDLE.
- DONE:
  - q holds its final value.
  - start → RUN; re-latch limit, q←0, pre←0.
  - stop → IDLE.
- Count sequence: one period is lim_r+1 ticks (0..lim_r). With lim_r=0, every tick is terminal.
- reload_en is sampled at each terminal event and may change mid-run.
- Changes to limit while busy have no effect until the next start from IDLE or DONE.
- q arithmetic is CNT_W-bit unsigned. No wrap can occur, because the terminal check precedes the increment.

## Timing
- All outputs are registered, including tick and done.
- start sampled in cycle N puts state=RUN in cycle N+1.
- The first tick asserts PRESCALE cycles after RUN entry. q updates in the cycle after tick.
- done is high in the same cycle that state first shows DONE, or the cycle q returns to 0 on reload.
- Simultaneous start+stop resolves to IDLE.
- A terminal tick coincident with stop has no done pulse; stop wins.
- Reset mid-run returns to the reset values on the next edge, regardless of commands.

## Configuration
- CNT_DOWN_EN defined:
  - dir port present and latched with limit on start.
  - Down mode loads q←lim_r at start.
  - Each non-terminal tick decrements q; terminal is q==0 at a tick.
  - Reload sets q←lim_r; one-shot holds q=0 in DONE.
- CNT_DOWN_EN undefined: dir port absent; up-count only.

## Test plan
- Use PRESCALE=4 for all scenarios.
- One-shot: limit=3, reload_en=0, start for one cycle → ticks every 4 cycles, q=0,1,2,3. On the 4th tick, done pulses once, state=11, q stays 3.
- Auto-reload: limit=2, reload_en=1 → q sequence 0,1,2,0,1,2. done pulses on every 3rd tick; state stays 01.
- Pause/resume: pause asserted 2 cycles after a tick → HOLD with q frozen. start 10 cycles later → next tick exactly 2 cycles after RUN re-entry.
- Priority and reset: start+stop together from HOLD → IDLE with q=0. rst mid-RUN → all outputs 0 the next cycle.
- Limit edge: limit=0, reload_en=0 → first tick asserts done, DONE with q=0. limit changed to 5 during RUN → no effect until restart from DONE.
- With CNT_DOWN_EN, dir=1, limit=3, one-shot → q=3,2,1,0, done on the 4th tick, DONE with q=0.
